// File: rtl/pipe_stage_skid.sv
// Parametrised pipeline stage register with a 2-entry skid buffer, a registered
// in_ready_o, synchronous flush, control masking on bubbles and saturating counters.
module pipe_stage_skid #(
  parameter int unsigned DATA_W = 128,
  parameter int unsigned CTRL_W = 2,
  parameter int unsigned RD_W   = 5,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic [CTRL_W-1:0] in_ctrl_i,
  input  logic [RD_W-1:0]   in_rd_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [CTRL_W-1:0] out_ctrl_o,
  output logic [RD_W-1:0]   out_rd_o,
  output logic [1:0]        occupancy_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  bubble_cnt_o
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   head_data_q, head_data_d;
  logic [CTRL_W-1:0]   head_ctrl_q, head_ctrl_d;
  logic [RD_W-1:0]     head_rd_q, head_rd_d;
  logic [DATA_W-1:0]   skid_data_q, skid_data_d;
  logic [CTRL_W-1:0]   skid_ctrl_q, skid_ctrl_d;
  logic [RD_W-1:0]     skid_rd_q, skid_rd_d;
  logic                in_ready_q, in_ready_d;
  logic                out_valid_q, out_valid_d;
  logic [CTRL_W-1:0]   out_ctrl_q, out_ctrl_d;
  logic [1:0]          occ_q, occ_d;
  logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]    bubble_cnt_q, bubble_cnt_d;
  logic                accept, pop;

  // Saturating increment: holds at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val,
                                               input logic             en);
    logic [CNT_W-1:0] res;
    if (en && (val != {CNT_W{1'b1}})) begin
      res = val + CNT_W'(1);
    end else begin
      res = val;
    end
    return res;
  endfunction

  assign accept = in_valid_i & in_ready_q;
  assign pop    = out_valid_q & out_ready_i;

  // Next-state and storage steering; flush overrides accept and pop.
  always_comb begin
    state_d     = state_q;
    head_data_d = head_data_q;
    head_ctrl_d = head_ctrl_q;
    head_rd_d   = head_rd_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_rd_d   = skid_rd_q;
    if (flush_i) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            head_data_d = in_data_i;
            head_ctrl_d = in_ctrl_i;
            head_rd_d   = in_rd_i;
            state_d     = ST_ONE;
          end else begin
            state_d = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (accept && pop) begin
            head_data_d = in_data_i;
            head_ctrl_d = in_ctrl_i;
            head_rd_d   = in_rd_i;
            state_d     = ST_ONE;
          end else if (accept) begin
            skid_data_d = in_data_i;
            skid_ctrl_d = in_ctrl_i;
            skid_rd_d   = in_rd_i;
            state_d     = ST_FULL;
          end else if (pop) begin
            state_d = ST_EMPTY;
          end else begin
            state_d = ST_ONE;
          end
        end
        ST_FULL: begin
          // in_ready_q is low here, so only a pop can move the state.
          if (pop) begin
            head_data_d = skid_data_q;
            head_ctrl_d = skid_ctrl_q;
            head_rd_d   = skid_rd_q;
            state_d     = ST_ONE;
          end else begin
            state_d = ST_FULL;
          end
        end
        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end
  end

  // Handshake/status outputs precomputed from the next state so they leave flops.
  always_comb begin
    in_ready_d  = (state_d != ST_FULL);
    out_valid_d = (state_d != ST_EMPTY);
    out_ctrl_d  = {CTRL_W{1'b0}};
    if (out_valid_d) begin
      out_ctrl_d = head_ctrl_d;
    end else begin
      out_ctrl_d = {CTRL_W{1'b0}};
    end
    case (state_d)
      ST_EMPTY: occ_d = 2'd0;
      ST_ONE:   occ_d = 2'd1;
      ST_FULL:  occ_d = 2'd2;
      default:  occ_d = 2'd0;
    endcase
  end

  // Performance counters qualify on the current outputs and skip flush cycles.
  always_comb begin
    stall_cnt_d  = sat_inc(stall_cnt_q, out_valid_q & ~out_ready_i & ~flush_i);
    bubble_cnt_d = sat_inc(bubble_cnt_q, ~out_valid_q & ~flush_i);
  end

  // Control state and registered handshake outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_ctrl_q  <= {CTRL_W{1'b0}};
      occ_q       <= 2'd0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_ctrl_q  <= out_ctrl_d;
      occ_q       <= occ_d;
    end
  end

  // Head and skid payload storage.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_data_q <= {DATA_W{1'b0}};
      head_ctrl_q <= {CTRL_W{1'b0}};
      head_rd_q   <= {RD_W{1'b0}};
      skid_data_q <= {DATA_W{1'b0}};
      skid_ctrl_q <= {CTRL_W{1'b0}};
      skid_rd_q   <= {RD_W{1'b0}};
    end else begin
      head_data_q <= head_data_d;
      head_ctrl_q <= head_ctrl_d;
      head_rd_q   <= head_rd_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_rd_q   <= skid_rd_d;
    end
  end

  // Stall and bubble counters, cleared only by reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_q  <= {CNT_W{1'b0}};
      bubble_cnt_q <= {CNT_W{1'b0}};
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign in_ready_o   = in_ready_q;
  assign out_valid_o  = out_valid_q;
  assign out_data_o   = head_data_q;
  assign out_ctrl_o   = out_ctrl_q;
  assign out_rd_o     = head_rd_q;
  assign occupancy_o  = occ_q;
  assign stall_cnt_o  = stall_cnt_q;
  assign bubble_cnt_o = bubble_cnt_q;

endmodule
